// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, LSB first, optional even/odd parity, one stop bit.
// Latency: result pulses one cycle after the stop-bit majority decision (mid stop bit).
// Backpressure: none; the receiver free-runs and each pulse lasts one cycle.
//
// Ports:
//   CLK, Reset         : clock and synchronous active-high reset
//   Rx_in              : serial line, idles high (synchronized internally)
//   Parity_EN          : 1 = a parity bit follows the data bits (latched at frame start)
//   Parity_type        : 0 = even, 1 = odd (latched at frame start)
//   Data               : last correctly received word
//   Data_valid         : one-cycle pulse when Data holds a new word
//   Parity_error       : one-cycle pulse on parity failure
//   Stop_error         : one-cycle pulse when the stop bit is low
//   Busy               : high whenever the FSM is not idle
module uart_rx #(
    parameter int width    = 8,
    parameter int Prescale = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Rx_in,
    input  logic             Parity_EN,
    input  logic             Parity_type,
    output logic [width-1:0] Data,
    output logic             Data_valid,
    output logic             Parity_error,
    output logic             Stop_error,
    output logic             Busy
);

    localparam int CW = (Prescale > 1) ? $clog2(Prescale) : 1;
    localparam int BW = (width > 1) ? $clog2(width) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(Prescale - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(Prescale / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(Prescale / 2);
    localparam logic [CW-1:0] CNT_DEC  = CW'(Prescale / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(width - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]       samp_q, samp_d;
    logic [width-1:0] shift_q, shift_d;
    logic             par_en_q, par_en_d;
    logic             par_type_q, par_type_d;
    logic             par_ok_q, par_ok_d;
    logic [width-1:0] data_q, data_d;
    logic             data_vld_q, data_vld_d;
    logic             par_err_q, par_err_d;
    logic             stop_err_q, stop_err_d;

    logic rx;
    logic vote;
    logic cnt_wrap;

    assign rx       = sync2_q;
    // Third sample is the live line at the decision count.
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx) | (samp_q[1] & rx);
    assign cnt_wrap = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        sync1_d    = Rx_in;
        sync2_d    = sync1_q;
        cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        par_ok_d   = par_ok_q;
        data_d     = data_q;
        data_vld_d = 1'b0;
        par_err_d  = 1'b0;
        stop_err_d = 1'b0;

        if (cnt_q == CNT_S0) samp_d[0] = rx;
        if (cnt_q == CNT_S1) samp_d[1] = rx;

        unique case (state_q)
            IDLE: begin
                // The first low cycle counts as cycle 0 of the start bit.
                cnt_d = '0;
                if (!rx) begin
                    state_d    = START;
                    cnt_d      = CW'(1);
                    bit_cnt_d  = '0;
                    par_en_d   = Parity_EN;
                    par_type_d = Parity_type;
                end
            end
            START: begin
                if (cnt_q == CNT_DEC && vote) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_DEC) shift_d = {vote, shift_q[width-1:1]};
                if (cnt_wrap) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == CNT_DEC) par_ok_d = (((^shift_q) ^ vote) == par_type_q);
                if (cnt_wrap) state_d = STOP;
            end
            STOP: begin
                // Leave mid stop bit so a following start edge is caught with no gap.
                if (cnt_q == CNT_DEC) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    stop_err_d = ~vote;
                    par_err_d  = par_en_q & ~par_ok_q;
                    if (vote && !(par_en_q && !par_ok_q)) begin
                        data_vld_d = 1'b1;
                        data_d     = shift_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_ok_q   <= 1'b0;
            data_q     <= '0;
            data_vld_q <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            par_ok_q   <= par_ok_d;
            data_q     <= data_d;
            data_vld_q <= data_vld_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
        end
    end

    assign Data         = data_q;
    assign Data_valid   = data_vld_q;
    assign Parity_error = par_err_q;
    assign Stop_error   = stop_err_q;
    assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with hand-computed outcomes checked through a scoreboard.
// Latency: stimulus is bit-timed at 8 clocks per bit; checks follow each result pulse.
// Backpressure: none; the monitor pops one expectation per observed pulse.
module tb_uart_rx;

    localparam int P = 8;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Rx_in;
    logic       Parity_EN;
    logic       Parity_type;
    logic [7:0] Data;
    logic       Data_valid;
    logic       Parity_error;
    logic       Stop_error;
    logic       Busy;

    uart_rx #(.width(8), .Prescale(P)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Rx_in        (Rx_in),
        .Parity_EN    (Parity_EN),
        .Parity_type  (Parity_type),
        .Data         (Data),
        .Data_valid   (Data_valid),
        .Parity_error (Parity_error),
        .Stop_error   (Stop_error),
        .Busy         (Busy)
    );

    always #5 CLK = ~CLK;

    // flags = {Data_valid, Parity_error, Stop_error}
    typedef struct {
        logic [2:0] flags;
        logic [7:0] dat;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        bit         pen;
        bit         ptype;
        bit         pbit;
        bit         stop;
        bit         flip;
        logic [2:0] flags;
    } vec_t;

    exp_t       exp_q[$];
    int         tests  = 0;
    int         failed = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] prev_data = 8'h00;
    bit         rst_window = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input vec_t v);
        exp_t e;
        if (v.flags[2]) last_good = v.d;
        e.flags = v.flags;
        e.dat   = last_good;
        exp_q.push_back(e);
        Parity_EN   = v.pen;
        Parity_type = v.ptype;
        Rx_in       = 1'b0;
        tick(P);
        check("busy_in_frame", {31'd0, Busy}, 32'd1);
        // Parity settings were latched at the start edge; toggling now must not matter.
        if (v.flip) Parity_type = ~v.ptype;
        for (int i = 0; i < 8; i++) begin
            Rx_in = v.d[i];
            tick(P);
        end
        if (v.pen) begin
            Rx_in = v.pbit;
            tick(P);
        end
        Rx_in = v.stop;
        tick(P);
        Rx_in       = 1'b1;
        Parity_type = v.ptype;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (Data_valid || Parity_error || Stop_error) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_pulse: got flags %b data 0x%02h, expected no pulse",
                         {Data_valid, Parity_error, Stop_error}, Data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_flags", {29'd0, Data_valid, Parity_error, Stop_error}, {29'd0, e.flags});
                check("pulse_data", {24'd0, Data}, {24'd0, e.dat});
            end
        end
        if (!rst_window && !Data_valid && Data !== prev_data) begin
            tests++;
            failed++;
            $display("FAIL data_stable: got 0x%02h, expected 0x%02h", Data, prev_data);
        end
        prev_data = Data;
    end

    vec_t vecs[5];
    vec_t v;

    initial begin
        //            d      pen ptype pbit stop flip  {dv,pe,se}
        vecs[0] = '{8'h55, 1,  0,    0,   1,   1,   3'b100}; // 4 ones, even -> pbit 0 ok
        vecs[1] = '{8'hAA, 1,  1,    1,   1,   0,   3'b100}; // 4 ones, odd  -> pbit 1 ok
        vecs[2] = '{8'hAA, 1,  1,    0,   1,   0,   3'b010}; // odd needs 1, got 0
        vecs[3] = '{8'hCA, 0,  0,    0,   0,   0,   3'b001}; // stop low
        vecs[4] = '{8'h01, 1,  0,    0,   0,   0,   3'b011}; // even needs 1, got 0; stop low

        Reset       = 1'b1;
        Rx_in       = 1'b1;
        Parity_EN   = 1'b0;
        Parity_type = 1'b0;
        tick(3);
        check("rst_data", {24'd0, Data}, 32'd0);
        check("rst_valid", {31'd0, Data_valid}, 32'd0);
        check("rst_perr", {31'd0, Parity_error}, 32'd0);
        check("rst_serr", {31'd0, Stop_error}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        Reset = 1'b0;
        tick(1);
        rst_window = 1'b0;
        tick(5);

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i]);
            tick(20);
        end

        // Two-cycle low glitch on an idle line.
        Rx_in = 1'b0;
        tick(2);
        Rx_in = 1'b1;
        tick(2);
        check("glitch_busy_rise", {31'd0, Busy}, 32'd1);
        tick(12);
        check("glitch_busy_fall", {31'd0, Busy}, 32'd0);
        tick(5);

        // Reset in the middle of bit 4 of 0x33.
        Parity_EN = 1'b0;
        Rx_in     = 1'b0;
        tick(P);
        for (int i = 0; i < 4; i++) begin
            Rx_in = (8'h33 >> i) & 8'h01;
            tick(P);
        end
        Rx_in = 1'b1;               // bit 4 of 0x33 is 1
        tick(3);
        rst_window = 1'b1;
        Reset      = 1'b1;
        tick(2);
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        check("midrst_data", {24'd0, Data}, 32'd0);
        Reset = 1'b0;
        last_good = 8'h00;
        tick(1);
        rst_window = 1'b0;
        tick(10);
        v = '{8'h0F, 1, 0, 0, 1, 0, 3'b100}; // 4 ones, even -> pbit 0 ok
        send_frame(v);
        tick(20);

        // Back-to-back frames, no idle gap between stop and next start.
        v = '{8'h12, 0, 0, 0, 1, 0, 3'b100};
        send_frame(v);
        v = '{8'h34, 0, 0, 0, 1, 0, 3'b100};
        send_frame(v);
        tick(30);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("end_idle", {31'd0, Busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the data bits per frame.
REQ-002 The block SHALL have parameter Prescale, default 8, giving clock cycles per bit; legal values are even and at least 4.
REQ-003 CLK  input  1  single clock; all logic SHALL update on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Rx_in  input  1  serial line; idles high.
REQ-006 Parity_EN  input  1  1 = a parity bit follows the data bits.
REQ-007 Parity_type  input  1  0 = even parity, 1 = odd parity.
REQ-008 Data  output  width  last correctly received word.
REQ-009 Data_valid  output  1  one-cycle pulse when Data holds a new good word.
REQ-010 Parity_error  output  1  one-cycle pulse when a frame fails the parity check.
REQ-011 Stop_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-012 Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Rx_in SHALL pass through a 2-flop synchronizer before any other use; its flops reset to 1. All timing below is relative to the synchronized line.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-015 A bit counter and a cycle counter (0..Prescale-1) SHALL track each bit position.
REQ-016 Each bit SHALL be resolved by a 2-of-3 majority vote of samples taken at cycle counts Prescale/2-1, Prescale/2 and Prescale/2+1. The decision is available at count Prescale/2+1.
REQ-017 IDLE -> START SHALL occur on the first cycle the synchronized line is low. The cycle counter starts at 0 on that cycle.
REQ-018 Parity_EN and Parity_type SHALL be latched at the IDLE -> START transition. Changes to them mid-frame SHALL have no effect on that frame.
REQ-019 START: if the voted start bit is 1 (a glitch), the FSM SHALL return to IDLE with no output pulse. Otherwise it SHALL enter DATA after count Prescale-1.
REQ-020 DATA: the block SHALL shift in width bits, LSB first, into an internal shift register. After the last bit it SHALL go to PARITY if parity is enabled, otherwise to STOP.
REQ-021 PARITY: the check SHALL pass when the XOR of the data bits and the received parity bit is 0 (even parity) or 1 (odd parity).
REQ-022 STOP: on the stop-bit decision cycle (count Prescale/2+1) the FSM SHALL return to IDLE. This lets a following start bit be detected without a gap.
REQ-023 On the cycle after the stop decision, with stop = 1 and parity passing or disabled:
- Data SHALL load the shift register.
- Data_valid SHALL be 1 for exactly one cycle.
REQ-024 On a parity failure, Parity_error SHALL pulse on the same cycle that Data_valid would have pulsed. Data_valid SHALL stay 0 and Data SHALL be unchanged.
REQ-025 When the stop bit samples 0, Stop_error SHALL pulse on that cycle. Data_valid SHALL stay 0 and Data SHALL be unchanged.
REQ-026 When both parity and stop fail, both error pulses SHALL assert together.
REQ-027 Data SHALL change only with a Data_valid pulse.
REQ-028 A stuck-low line after a stop error SHALL be treated as a new start bit.
REQ-029 Counters SHALL wrap from Prescale-1 to 0. The bit counter SHALL be cleared on every IDLE exit.

Reset
REQ-030 While Reset = 1 at a clock edge:
- FSM -> IDLE, all counters -> 0.
- Data -> 0.
- Data_valid, Parity_error, Stop_error, Busy -> 0.
- Synchronizer flops -> 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no pulse. Reception SHALL resume on the first low sample after Reset deasserts.

Verification
REQ-032 Prescale = 8, Parity_EN = 1, Parity_type = 0, frame 0x55 with parity 0 -> Data = 0x55, one Data_valid pulse, no error pulses.
REQ-033 Parity_type = 1, frame 0xAA with parity 1 -> Data = 0xAA with a valid pulse. The same frame with parity 0 -> one Parity_error pulse, Data stays 0xAA.
REQ-034 Parity_EN = 0, frame 0xCA then stop bit 0 -> one Stop_error pulse, no Data_valid, Data unchanged.
REQ-035 A 2-cycle low glitch on an idle line -> FSM returns to IDLE, Busy falls, no pulses.
REQ-036 Reset pulsed during bit 4 of 0x33, followed by a clean 0x0F frame -> only 0x0F is reported.
REQ-037 Two back-to-back frames, 0x12 then 0x34, with one stop bit each -> two Data_valid pulses, Data = 0x12 then 0x34.
